bus_dma: RTL and testbench



---
 rtl/bus_dma_pkg.sv | 33 +++
 rtl/bus_if.sv | 15 +
 rtl/bus_dma.sv | 160 ++++++++++++++++
 tb/tb_bus_dma.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dma_pkg.sv
// Shared types, register offsets and CTRL bit positions for the bus_dma word-copy engine.
package bus_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } dma_state_t;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_DONE   = 2;

    // Merge new_v into old_v byte by byte where the strobe is set.
    function automatic logic [31:0] apply_wstrobe(input logic [31:0] old_v,
                                                  input logic [31:0] new_v,
                                                  input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Simple valid/ready bus shared by the CPU register port and the DMA initiator port.
interface Bus;
    logic        valid;
    logic        ready;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport m (output valid, output address, output wstrobe, output wdata,
               input ready, input rdata, input irq);
    modport s (input valid, input address, input wstrobe, input wdata,
               output ready, output rdata, output irq);
endinterface

// File: rtl/bus_dma.sv
// Word-copy DMA: CPU-visible SRC/DST/LEN/CTRL registers plus a read-then-write
// initiator FSM that moves one 32-bit word per read/write pair.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    Bus.s       reg_bus,
    Bus.m       mem_bus
);

    dma_state_t           state_q;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [31:0]          buf_q;
    logic                 done_q;
    logic                 irq_en_q;
    logic                 valid_q;
    logic [31:0]          addr_q;
    logic [3:0]           wstrb_q;
    logic [31:0]          wdata_q;

    logic [31:0]          src_d;
    logic [31:0]          dst_d;
    logic [LEN_WIDTH-1:0] len_d;
    logic [31:0]          rdata_s;

    logic       busy_s;
    logic       reg_wr_s;
    logic [1:0] sel_s;
    logic       ctrl_wr_s;
    logic       start_s;
    logic       start_go_s;
    logic       start_zero_s;
    logic       clr_done_s;
    logic       mem_acc_s;
    logic       last_word_s;

    assign busy_s       = (state_q != IDLE);
    assign sel_s        = reg_bus.address[3:2];
    assign reg_wr_s     = reg_bus.valid && (reg_bus.wstrobe != 4'h0);
    assign ctrl_wr_s    = reg_wr_s && (sel_s == REG_CTRL) && reg_bus.wstrobe[0];
    assign start_s      = ctrl_wr_s && reg_bus.wdata[CTRL_START] && !busy_s;
    assign start_go_s   = start_s && (len_q != '0);
    assign start_zero_s = start_s && (len_q == '0);
    assign clr_done_s   = ctrl_wr_s && reg_bus.wdata[CTRL_DONE];
    assign mem_acc_s    = valid_q && mem_bus.ready;
    assign last_word_s  = (state_q == WRITE) && mem_acc_s && (len_q == LEN_WIDTH'(1));

    // Addresses are word aligned; LEN keeps only its low LEN_WIDTH bits.
    assign src_d = apply_wstrobe(src_q, reg_bus.wdata, reg_bus.wstrobe) & 32'hFFFF_FFFC;
    assign dst_d = apply_wstrobe(dst_q, reg_bus.wdata, reg_bus.wstrobe) & 32'hFFFF_FFFC;
    assign len_d = LEN_WIDTH'(apply_wstrobe(32'(len_q), reg_bus.wdata, reg_bus.wstrobe));

    // Zero-latency register read mux, quiet when no access is presented.
    always_comb begin
        rdata_s = 32'h0;
        if (reg_bus.valid) begin
            case (sel_s)
                REG_SRC: rdata_s = src_q;
                REG_DST: rdata_s = dst_q;
                REG_LEN: rdata_s = 32'(len_q);
                default: rdata_s = {29'h0, done_q, irq_en_q, busy_s};
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign reg_bus.ready = reg_bus.valid;
    assign reg_bus.rdata = rdata_s;
    assign reg_bus.irq   = done_q && irq_en_q;

    assign mem_bus.valid   = valid_q;
    assign mem_bus.address = addr_q;
    assign mem_bus.wstrobe = wstrb_q;
    assign mem_bus.wdata   = wdata_q;

    // Register file and initiator FSM share SRC/DST/LEN, so both live here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            src_q    <= 32'h0;
            dst_q    <= 32'h0;
            len_q    <= '0;
            buf_q    <= 32'h0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= 32'h0;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
        end else begin
            if (reg_wr_s && !busy_s) begin
                case (sel_s)
                    REG_SRC: src_q <= src_d;
                    REG_DST: dst_q <= dst_d;
                    REG_LEN: len_q <= len_d;
                    default: ;
                endcase
            end

            if (ctrl_wr_s) begin
                irq_en_q <= reg_bus.wdata[CTRL_IRQ_EN];
            end

            // A hardware completion beats a same-cycle CPU clear.
            if (last_word_s || start_zero_s) begin
                done_q <= 1'b1;
            end else if (start_go_s || clr_done_s) begin
                done_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start_go_s) begin
                        state_q <= READ;
                        valid_q <= 1'b1;
                        addr_q  <= src_q;
                        wstrb_q <= 4'h0;
                    end
                end
                READ: begin
                    if (mem_acc_s) begin
                        buf_q   <= mem_bus.rdata;
                        wdata_q <= mem_bus.rdata;
                        addr_q  <= dst_q;
                        wstrb_q <= 4'hF;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_acc_s) begin
                        src_q <= src_q + 32'd4;
                        dst_q <= dst_q + 32'd4;
                        len_q <= len_q - LEN_WIDTH'(1);
                        wstrb_q <= 4'h0;
                        if (len_q == LEN_WIDTH'(1)) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            addr_q  <= 32'h0;
                        end else begin
                            state_q <= READ;
                            addr_q  <= src_q + 32'd4;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    wstrb_q <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// Bench for bus_dma: register vector table, scoreboarded RAM slave with wait states,
// and directed sequences for irq, zero-length, busy-ignore and mid-transfer reset.
module tb_bus_dma;
    import bus_dma_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    Bus reg_bus();
    Bus mem_bus();

    bus_dma #(.LEN_WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .reg_bus (reg_bus),
        .mem_bus (mem_bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // RAM slave model with programmable wait states
    logic [31:0] ram [0:255];
    int wait_n = 0;
    int wait_cnt = 0;
    int vcycles = 0;
    logic rst_seen = 1'b0;

    assign mem_bus.ready = mem_bus.valid && (wait_cnt >= wait_n);
    assign mem_bus.rdata = ram[mem_bus.address[9:2]];
    assign mem_bus.irq   = 1'b0;

    always @(posedge clk) begin
        rst_seen <= reset;
        if (reset) begin
            wait_cnt <= 0;
        end else if (mem_bus.valid && mem_bus.ready) begin
            wait_cnt <= 0;
            if (mem_bus.wstrobe != 4'h0) ram[mem_bus.address[9:2]] <= mem_bus.wdata;
        end else if (mem_bus.valid) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t exp_q[$];

    logic        stable_pend = 1'b0;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_strb;

    // Scoreboard and hold-stable monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_seen || reset) begin
            stable_pend = 1'b0;
        end else begin
            if (stable_pend) begin
                check("hold_valid", {31'h0, mem_bus.valid}, 32'h1);
                check("hold_addr", mem_bus.address, snap_addr);
                check("hold_strb", {28'h0, mem_bus.wstrobe}, {28'h0, snap_strb});
                check("hold_wdata", mem_bus.wdata, snap_wdata);
                stable_pend = 1'b0;
            end
            if (mem_bus.valid) begin
                vcycles++;
                if (mem_bus.ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_txn", mem_bus.address, 32'hDEAD_DEAD);
                    end else begin
                        txn_t e;
                        e = exp_q.pop_front();
                        check("txn_addr", mem_bus.address, e.addr);
                        check("txn_strb", {28'h0, mem_bus.wstrobe}, e.wr ? 32'hF : 32'h0);
                        if (e.wr) check("txn_wdata", mem_bus.wdata, e.data);
                    end
                end else begin
                    snap_addr   = mem_bus.address;
                    snap_wdata  = mem_bus.wdata;
                    snap_strb   = mem_bus.wstrobe;
                    stable_pend = 1'b1;
                end
            end
        end
    end

    task automatic reg_wr(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] strb);
        @(negedge clk);
        reg_bus.valid   = 1'b1;
        reg_bus.address = {28'h0, idx, 2'b00};
        reg_bus.wstrobe = strb;
        reg_bus.wdata   = d;
        @(posedge clk);
        #1;
        reg_bus.valid   = 1'b0;
        reg_bus.wstrobe = 4'h0;
    endtask

    task automatic reg_rd(input logic [1:0] idx, output logic [31:0] d);
        @(negedge clk);
        reg_bus.valid   = 1'b1;
        reg_bus.address = {28'h0, idx, 2'b00};
        reg_bus.wstrobe = 4'h0;
        #1;
        d = reg_bus.rdata;
        check("reg_ready", {31'h0, reg_bus.ready}, 32'h1);
        @(posedge clk);
        #1;
        reg_bus.valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] d;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            reg_rd(REG_CTRL, d);
            if (d[CTRL_DONE]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] dd, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{1'b0, s + 32'(4*i), 32'h0});
            exp_q.push_back('{1'b1, dd + 32'(4*i), 32'h11 * 32'(i+1)});
        end
    endtask

    task automatic setup(input logic [31:0] s, input logic [31:0] dd, input logic [31:0] n);
        reg_wr(REG_CTRL, 32'h4, 4'h1);
        reg_wr(REG_SRC, s, 4'hF);
        reg_wr(REG_DST, dd, 4'hF);
        reg_wr(REG_LEN, n, 4'hF);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  idx;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[24];

    logic [31:0] rd;

    initial begin
        vecs[0]  = '{1'b0, REG_SRC,  4'h0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, REG_DST,  4'h0, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, REG_LEN,  4'h0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, REG_CTRL, 4'h0, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, REG_SRC,  4'hF, 32'h1234_5677, 32'h0};
        vecs[5]  = '{1'b0, REG_SRC,  4'h0, 32'h0,         32'h1234_5674};
        vecs[6]  = '{1'b1, REG_SRC,  4'h2, 32'hAABB_CCDD, 32'h0};
        vecs[7]  = '{1'b0, REG_SRC,  4'h0, 32'h0,         32'h1234_CC74};
        vecs[8]  = '{1'b1, REG_DST,  4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, REG_DST,  4'h0, 32'h0,         32'hFFFF_FFFC};
        vecs[10] = '{1'b1, REG_LEN,  4'hF, 32'hABCD_1234, 32'h0};
        vecs[11] = '{1'b0, REG_LEN,  4'h0, 32'h0,         32'h0000_1234};
        vecs[12] = '{1'b1, REG_LEN,  4'hC, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b0, REG_LEN,  4'h0, 32'h0,         32'h0000_1234};
        vecs[14] = '{1'b1, REG_LEN,  4'h1, 32'h0000_00FF, 32'h0};
        vecs[15] = '{1'b0, REG_LEN,  4'h0, 32'h0,         32'h0000_12FF};
        vecs[16] = '{1'b1, REG_CTRL, 4'h1, 32'h0000_0002, 32'h0};
        vecs[17] = '{1'b0, REG_CTRL, 4'h0, 32'h0,         32'h0000_0002};
        vecs[18] = '{1'b1, REG_CTRL, 4'h1, 32'h0000_0000, 32'h0};
        vecs[19] = '{1'b0, REG_CTRL, 4'h0, 32'h0,         32'h0};
        vecs[20] = '{1'b1, REG_CTRL, 4'h2, 32'h0000_0203, 32'h0};
        vecs[21] = '{1'b0, REG_CTRL, 4'h0, 32'h0,         32'h0};
        vecs[22] = '{1'b1, REG_LEN,  4'hF, 32'h0,         32'h0};
        vecs[23] = '{1'b0, REG_LEN,  4'h0, 32'h0,         32'h0};

        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4; i++) ram[16+i] = 32'h11 * 32'(i+1);
        reg_bus.valid = 1'b0; reg_bus.address = 32'h0;
        reg_bus.wstrobe = 4'h0; reg_bus.wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", {31'h0, mem_bus.valid}, 32'h0);
        check("rst_mem_addr", mem_bus.address, 32'h0);
        check("rst_mem_wdata", mem_bus.wdata, 32'h0);
        check("rst_irq", {31'h0, reg_bus.irq}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].wr) reg_wr(vecs[i].idx, vecs[i].data, vecs[i].strb);
            else begin
                reg_rd(vecs[i].idx, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].exp);
            end
        end

        // Zero-wait copy of four words.
        setup(32'h40, 32'h80, 32'd4);
        push_copy(32'h40, 32'h80, 4);
        vcycles = 0;
        reg_wr(REG_CTRL, 32'h1, 4'h1);
        wait_done("copy0_done");
        check("copy0_vcycles", 32'(vcycles), 32'd8);
        for (int i = 0; i < 4; i++) check("copy0_data", ram[32+i], 32'h11 * 32'(i+1));
        reg_rd(REG_SRC, rd);  check("copy0_src", rd, 32'h50);
        reg_rd(REG_DST, rd);  check("copy0_dst", rd, 32'h90);
        reg_rd(REG_LEN, rd);  check("copy0_len", rd, 32'h0);
        reg_rd(REG_CTRL, rd); check("copy0_ctrl", rd, 32'h4);
        reg_bus.address = 32'hC;
        #1 check("rdata_idle", reg_bus.rdata, 32'h0);

        // Same copy with two wait states per access.
        for (int i = 0; i < 4; i++) ram[32+i] = 32'h0;
        wait_n = 2;
        setup(32'h40, 32'h80, 32'd4);
        push_copy(32'h40, 32'h80, 4);
        vcycles = 0;
        reg_wr(REG_CTRL, 32'h1, 4'h1);
        wait_done("copy1_done");
        check("copy1_vcycles", 32'(vcycles), 32'd24);
        for (int i = 0; i < 4; i++) check("copy1_data", ram[32+i], 32'h11 * 32'(i+1));
        wait_n = 0;

        // irq with irq_en, then clear-done; then irq_en off.
        setup(32'h40, 32'hC0, 32'd1);
        push_copy(32'h40, 32'hC0, 1);
        reg_wr(REG_CTRL, 32'h3, 4'h1);
        wait_done("irq_done");
        check("irq_high", {31'h0, reg_bus.irq}, 32'h1);
        reg_rd(REG_CTRL, rd); check("irq_ctrl", rd, 32'h6);
        reg_wr(REG_CTRL, 32'h6, 4'h1);
        check("irq_cleared", {31'h0, reg_bus.irq}, 32'h0);
        reg_rd(REG_CTRL, rd); check("irq_ctrl2", rd, 32'h2);
        reg_wr(REG_LEN, 32'd1, 4'hF);
        reg_wr(REG_SRC, 32'h40, 4'hF);
        push_copy(32'h40, 32'hC4, 1);
        reg_wr(REG_CTRL, 32'h1, 4'h1);
        wait_done("noirq_done");
        check("noirq_low", {31'h0, reg_bus.irq}, 32'h0);
        reg_rd(REG_CTRL, rd); check("noirq_ctrl", rd, 32'h4);

        // Zero-length start.
        setup(32'h40, 32'h80, 32'd0);
        vcycles = 0;
        reg_wr(REG_CTRL, 32'h1, 4'h1);
        reg_rd(REG_CTRL, rd); check("zlen_ctrl", rd, 32'h4);
        repeat (10) @(posedge clk);
        check("zlen_vcycles", 32'(vcycles), 32'd0);

        // Writes while busy are ignored.
        wait_n = 1;
        setup(32'h40, 32'h100, 32'd3);
        push_copy(32'h40, 32'h100, 3);
        reg_wr(REG_CTRL, 32'h1, 4'h1);
        reg_wr(REG_SRC, 32'h100, 4'hF);
        reg_wr(REG_CTRL, 32'h1, 4'h1);
        wait_done("busy_done");
        reg_rd(REG_SRC, rd); check("busy_src", rd, 32'h4C);
        reg_rd(REG_DST, rd); check("busy_dst", rd, 32'h10C);
        check("busy_q_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) check("busy_data", ram[64+i], 32'h11 * 32'(i+1));

        // Reset in the WRITE phase.
        wait_n = 3;
        setup(32'h40, 32'h180, 32'd2);
        push_copy(32'h40, 32'h180, 2);
        reg_wr(REG_CTRL, 32'h3, 4'h1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (mem_bus.valid && mem_bus.wstrobe == 4'hF) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rst_reach_write", {31'h0, seen}, 32'h1);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid_low", {31'h0, mem_bus.valid}, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        wait_n = 0;
        reg_rd(REG_SRC, rd);  check("rst_src", rd, 32'h0);
        reg_rd(REG_DST, rd);  check("rst_dst", rd, 32'h0);
        reg_rd(REG_LEN, rd);  check("rst_len", rd, 32'h0);
        reg_rd(REG_CTRL, rd); check("rst_ctrl", rd, 32'h0);
        check("rst_irq2", {31'h0, reg_bus.irq}, 32'h0);
        setup(32'h40, 32'h200, 32'd1);
        push_copy(32'h40, 32'h200, 1);
        reg_wr(REG_CTRL, 32'h1, 4'h1);
        wait_done("fresh_done");
        check("fresh_data", ram[128], 32'h11);
        check("fresh_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
